pipe_hazard_ctrl: RTL
=====================

# pipe_hazard_ctrl

Pipeline hazard controller and register-address pipeline for the 5-stage CPU. It carries each instruction's source/destination register addresses and write/memory flags from Decode through Execute, Memory and Writeback, and it supplies these directly to the forwarding unit. It also detects load-use hazards, data-bus wait states and taken branches, and drives the per-stage stall, flush and bubble controls.

## Interface
Parameters:
- p_ADDR_W, 5, register address width.

Ports:
- i_Clk  in  1  core clock; all state updates on the rising edge.
- i_Rst_n  in  1  reset, asynchronous, active-low.
- i_Valid_D  in  1  Decode holds a real instruction.
- i_RS1Addr_D, i_RS2Addr_D, i_RDAddr_D  in  p_ADDR_W  Decode register addresses.
- i_RegWrEn_D  in  1  Decode instruction writes RD.
- i_MemRd_D  in  1  Decode instruction is a load.
- i_MemWr_D  in  1  Decode instruction is a store.
- i_BranchTaken_E  in  1  branch/jump in Execute resolved taken.
- i_DBusStall_M  in  1  Memory stage waiting on the data bus.
- o_RS1Addr_E, o_RS2Addr_E  out  p_ADDR_W  Execute source addresses.
- o_RS2Addr_M, o_RDAddr_M  out  p_ADDR_W  Memory stage addresses.
- o_RDAddr_W  out  p_ADDR_W  Writeback destination.
- o_RegWrEn_M, o_RegWrEn_W  out  1  write enables, already gated by stage valid.
- o_MemRd_E  out  1  Execute holds a valid load.
- o_StallF, o_StallD  out  1  hold PC / IF-ID register.
- o_StallE, o_StallM  out  1  hold ID-EX / EX-MEM registers.
- o_FlushD  out  1  squash IF-ID register.
- o_BubbleE  out  1  insert NOP into ID-EX register.
- o_BubbleW  out  1  insert NOP into MEM-WB register.

## Operation
- Internal stage registers:
  - E: Valid, RS1, RS2, RD, RegWrEn, MemRd.
  - M: Valid, RS2, RD, RegWrEn.
  - W: Valid, RD, RegWrEn.
- The RegWrEn outputs equal RegWrEn AND Valid of the same stage. The address outputs are the raw registers.
- Load-use hazard (LU) asserts when all of the following hold:
  - Valid_E, MemRd_E and RD_E != 0.
  - i_Valid_D.
  - Either RD_E == i_RS1Addr_D, or RD_E == i_RS2Addr_D and NOT (i_MemWr_D and RD_E != i_RS1Addr_D).
  - The store-data-only case is exempt because the store data is supplied by Memory-stage bus-data forwarding from Writeback.
- Priority, highest first:
  - DBus stall (DS = i_DBusStall_M):
    - o_StallF/D/E/M = 1 and o_BubbleW = 1.
    - The E and M registers hold their values.
    - W loads Valid=0 and RegWrEn=0; RD is don't-care but is held.
  - Branch (BR = i_BranchTaken_E & Valid_E & !DS):
    - o_FlushD = 1 and o_BubbleE = 1.
    - LU is ignored because Decode holds a wrong-path instruction.
  - Load-use (LU & !DS & !BR):
    - o_StallF = o_StallD = 1 and o_BubbleE = 1.
    - E loads Valid=0; M and W advance normally.
  - Otherwise: all stages advance. E←D fields with Valid=i_Valid_D, M←E, W←M.
- Bubble loads clear Valid, RegWrEn and MemRd. The address fields load the incoming values, but downstream consumers gate them with RegWrEn.
- Address 0 is never treated as a hazard source.

## Timing
- All control outputs are combinational from the current state and inputs, valid in the same cycle.
- Stage registers update on the rising edge of i_Clk.
- Reset (i_Rst_n low, asynchronous, at any time including during a stall) clears every stage register to 0. Resulting output values:
  - All address outputs = 0.
  - o_RegWrEn_M, o_RegWrEn_W, o_MemRd_E = 0.
  - Stall, flush and bubble outputs = 0.
- Load-use costs exactly 1 bubble cycle. In the next cycle the load is in M, LU deasserts, and the dependent instruction enters E.
- DS may last any number of cycles. While it is asserted, a branch held in E is deferred, and its flush occurs in the first cycle after DS deasserts.
- BR and LU in the same cycle: flush only, no extra stall cycle.

## Configuration
- HAZARD_PERF_CNT_EN defined:
  - Adds outputs o_LoadUseCnt and o_DBusStallCnt, 32 bits each, reset to 0.
  - o_LoadUseCnt increments on every cycle where the load-use row applies.
  - o_DBusStallCnt increments on every cycle where DS is asserted.
  - Both counters wrap modulo 2^32.
- HAZARD_PERF_CNT_EN undefined: the counters and their ports do not exist. All other behaviour is identical.

## Test plan
- Load x5 then `add x6,x5,x1` back-to-back:
  - Cycle with the load in E: o_StallF=o_StallD=o_BubbleE=1.
  - Next cycle: controls are 0, o_RDAddr_M=5, o_RegWrEn_M=1, o_RS1Addr_E=5.
- Load x5 then `sw x5,0(x2)`: no stall. Two cycles later o_RS2Addr_M=5, o_RDAddr_W=5, o_RegWrEn_W=1.
- Load x0 followed by `add x6,x0,x0`: LU never asserts.
- i_DBusStall_M held for 3 cycles with a load in M:
  - o_StallF/D/E/M=1 for 3 cycles.
  - o_RegWrEn_W=0 for 3 cycles.
  - E and M addresses remain unchanged.
- i_BranchTaken_E=1 with load-use also present: o_FlushD=o_BubbleE=1 and o_StallD=0. Next cycle Valid_E=0.
- Assert i_Rst_n=0 mid-DBus-stall: all outputs go to 0 immediately, without waiting for a clock edge. With HAZARD_PERF_CNT_EN defined, both counters read 0.

Source files
------------

// File: rtl/pipe_hazard_ctrl.sv
// Hazard controller and register-address pipeline (Decode -> Execute -> Memory -> Writeback).
// Optional perf counters are enabled by defining HAZARD_PERF_CNT_EN.
module pipe_hazard_ctrl #(
   parameter int p_ADDR_W = 5
) (
   input  logic                i_Clk,
   input  logic                i_Rst_n,
   input  logic                i_Valid_D,
   input  logic [p_ADDR_W-1:0] i_RS1Addr_D,
   input  logic [p_ADDR_W-1:0] i_RS2Addr_D,
   input  logic [p_ADDR_W-1:0] i_RDAddr_D,
   input  logic                i_RegWrEn_D,
   input  logic                i_MemRd_D,
   input  logic                i_MemWr_D,
   input  logic                i_BranchTaken_E,
   input  logic                i_DBusStall_M,
   output logic [p_ADDR_W-1:0] o_RS1Addr_E,
   output logic [p_ADDR_W-1:0] o_RS2Addr_E,
   output logic [p_ADDR_W-1:0] o_RS2Addr_M,
   output logic [p_ADDR_W-1:0] o_RDAddr_M,
   output logic [p_ADDR_W-1:0] o_RDAddr_W,
   output logic                o_RegWrEn_M,
   output logic                o_RegWrEn_W,
   output logic                o_MemRd_E,
   output logic                o_StallF,
   output logic                o_StallD,
   output logic                o_StallE,
   output logic                o_StallM,
   output logic                o_FlushD,
   output logic                o_BubbleE,
   output logic                o_BubbleW
`ifdef HAZARD_PERF_CNT_EN
   ,
   output logic [31:0]         o_LoadUseCnt,
   output logic [31:0]         o_DBusStallCnt
`endif
);

   logic                valid_e, regwr_e, memrd_e;
   logic [p_ADDR_W-1:0] rs1_e, rs2_e, rd_e;
   logic                valid_m, regwr_m;
   logic [p_ADDR_W-1:0] rs2_m, rd_m;
   logic                valid_w, regwr_w;
   logic [p_ADDR_W-1:0] rd_w;

   logic ds, br, lu, lu_act, kill_e;

   // Reset also masks the bus-stall input so every control drops at once during reset.
   assign ds = i_DBusStall_M & i_Rst_n;
   assign br = i_BranchTaken_E & valid_e & ~ds;

   // A store whose only dependency is its data operand is served by bus-data forwarding.
   always_comb begin
      lu = 1'b0;
      if (valid_e && memrd_e && (rd_e != '0) && i_Valid_D) begin
         if (rd_e == i_RS1Addr_D)
            lu = 1'b1;
         else if ((rd_e == i_RS2Addr_D) && !i_MemWr_D)
            lu = 1'b1;
      end
   end

   assign lu_act = lu & ~ds & ~br;
   assign kill_e = br | lu_act;

   assign o_StallF  = ds | lu_act;
   assign o_StallD  = ds | lu_act;
   assign o_StallE  = ds;
   assign o_StallM  = ds;
   assign o_FlushD  = br;
   assign o_BubbleE = kill_e;
   assign o_BubbleW = ds;

   assign o_RS1Addr_E = rs1_e;
   assign o_RS2Addr_E = rs2_e;
   assign o_RS2Addr_M = rs2_m;
   assign o_RDAddr_M  = rd_m;
   assign o_RDAddr_W  = rd_w;
   assign o_RegWrEn_M = regwr_m & valid_m;
   assign o_RegWrEn_W = regwr_w & valid_w;
   assign o_MemRd_E   = memrd_e & valid_e;

   always_ff @(posedge i_Clk or negedge i_Rst_n) begin
      if (!i_Rst_n) begin
         valid_e <= 1'b0;
         regwr_e <= 1'b0;
         memrd_e <= 1'b0;
         rs1_e   <= '0;
         rs2_e   <= '0;
         rd_e    <= '0;
         valid_m <= 1'b0;
         regwr_m <= 1'b0;
         rs2_m   <= '0;
         rd_m    <= '0;
         valid_w <= 1'b0;
         regwr_w <= 1'b0;
         rd_w    <= '0;
      end else if (ds) begin
         valid_w <= 1'b0;
         regwr_w <= 1'b0;
      end else begin
         valid_e <= i_Valid_D & ~kill_e;
         regwr_e <= i_RegWrEn_D & ~kill_e;
         memrd_e <= i_MemRd_D & ~kill_e;
         rs1_e   <= i_RS1Addr_D;
         rs2_e   <= i_RS2Addr_D;
         rd_e    <= i_RDAddr_D;
         valid_m <= valid_e;
         regwr_m <= regwr_e;
         rs2_m   <= rs2_e;
         rd_m    <= rd_e;
         valid_w <= valid_m;
         regwr_w <= regwr_m;
         rd_w    <= rd_m;
      end
   end

`ifdef HAZARD_PERF_CNT_EN
   always_ff @(posedge i_Clk or negedge i_Rst_n) begin
      if (!i_Rst_n) begin
         o_LoadUseCnt   <= '0;
         o_DBusStallCnt <= '0;
      end else begin
         if (lu_act)
            o_LoadUseCnt <= o_LoadUseCnt + 32'd1;
         if (ds)
            o_DBusStallCnt <= o_DBusStallCnt + 32'd1;
      end
   end
`endif

endmodule
